// File: rtl/dram_arbiter.sv
// Single-port Data RAM arbiter: pipeline port A (fixed priority) and debug port B (starvation guard).
// Optional alignment check is compiled in when DRAM_ARB_ALIGN_CHECK_EN is defined.
module dram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [3:0]        a_sel,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_ack,
    output logic              a_stall,
    output logic              a_err,
    input  logic              b_valid,
    input  logic              b_we,
    input  logic [3:0]        b_sel,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ready,
    output logic [31:0]       b_rdata,
    output logic              b_rvalid,
    output logic              b_err,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_sel_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_A = 2'd1,
        RESP_B = 2'd2
    } state_t;

`ifdef DRAM_ARB_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        if (sel == 4'b0011) begin
            bad = lsb[0];
        end else if (sel == 4'b1111) begin
            bad = (lsb != 2'b00);
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction
`endif

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_nxt_s;
    logic              resp_we_r, resp_we_nxt_s;
    logic              resp_err_r, resp_err_nxt_s;
    logic              a_elig_s, b_elig_s, force_b_s;
    logic              grant_a_s, grant_b_s, mis_s;
    logic              win_we_s;
    logic [3:0]        win_sel_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [31:0]       win_wdata_s;

    // Grant decision and RAM command mux; a requester is never re-granted in its own ack cycle
    always_comb begin
        a_elig_s  = a_req && (state_r != RESP_A);
        b_elig_s  = b_valid && (state_r != RESP_B);
        force_b_s = (wait_cnt_r == CNT_MAX);
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (b_elig_s && (!a_elig_s || force_b_s)) begin
            grant_b_s = 1'b1;
        end else if (a_elig_s) begin
            grant_a_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
        if (grant_b_s) begin
            win_we_s    = b_we;
            win_sel_s   = b_sel;
            win_addr_s  = b_addr;
            win_wdata_s = b_wdata;
        end else begin
            win_we_s    = a_we;
            win_sel_s   = a_sel;
            win_addr_s  = a_addr;
            win_wdata_s = a_wdata;
        end
`ifdef DRAM_ARB_ALIGN_CHECK_EN
        mis_s = (grant_a_s || grant_b_s) && misaligned(win_sel_s, win_addr_s[1:0]);
`else
        mis_s = 1'b0;
`endif
        ram_ce_o = (grant_a_s || grant_b_s) && !mis_s;
        if (ram_ce_o) begin
            ram_we_o    = win_we_s;
            ram_sel_o   = win_sel_s;
            ram_addr_o  = win_addr_s;
            ram_wdata_o = win_wdata_s;
        end else begin
            ram_we_o    = 1'b0;
            ram_sel_o   = 4'b0000;
            ram_addr_o  = {ADDR_W{1'b0}};
            ram_wdata_o = 32'd0;
        end
        b_ready = grant_b_s;
        a_stall = a_req && !a_ack;
    end

    // Next response owner and B starvation counter
    always_comb begin
        state_nxt_s    = IDLE;
        resp_we_nxt_s  = 1'b0;
        resp_err_nxt_s = 1'b0;
        wait_cnt_nxt_s = {CNT_W{1'b0}};
        if (grant_a_s) begin
            state_nxt_s    = RESP_A;
            resp_we_nxt_s  = win_we_s;
            resp_err_nxt_s = mis_s;
        end else if (grant_b_s) begin
            state_nxt_s    = RESP_B;
            resp_we_nxt_s  = win_we_s;
            resp_err_nxt_s = mis_s;
        end else begin
            state_nxt_s = IDLE;
        end
        if (b_valid && !grant_b_s) begin
            wait_cnt_nxt_s = force_b_s ? CNT_MAX : (wait_cnt_r + CNT_ONE);
        end else begin
            wait_cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // State and response-attribute registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            resp_we_r  <= 1'b0;
            resp_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            resp_we_r  <= resp_we_nxt_s;
            resp_err_r <= resp_err_nxt_s;
        end
    end

    // Response decode: read data arrives from the RAM in the owner's response cycle
    always_comb begin
        a_ack    = 1'b0;
        a_err    = 1'b0;
        a_rdata  = 32'd0;
        b_rvalid = 1'b0;
        b_err    = 1'b0;
        b_rdata  = 32'd0;
        case (state_r)
            RESP_A: begin
                a_ack   = 1'b1;
                a_err   = resp_err_r;
                a_rdata = (resp_we_r || resp_err_r) ? 32'd0 : ram_rdata_i;
            end
            RESP_B: begin
                b_rvalid = 1'b1;
                b_err    = resp_err_r;
                b_rdata  = (resp_we_r || resp_err_r) ? 32'd0 : ram_rdata_i;
            end
            default: begin
                a_ack    = 1'b0;
                b_rvalid = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// Randomised bench for dram_arbiter with a transaction-level model and a shadow memory.
module tb_dram_arbiter;
    localparam int AW = 12;
    // A single-slot wait budget makes the forced-B path reachable from real traffic.
    localparam int MW = 1;
`ifdef DRAM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk, rst;
    logic a_req, a_we, a_ack, a_stall, a_err;
    logic [3:0] a_sel;
    logic [AW-1:0] a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic b_valid, b_we, b_ready, b_rvalid, b_err;
    logic [3:0] b_sel;
    logic [AW-1:0] b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic ram_ce_o, ram_we_o;
    logic [3:0] ram_sel_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0] ram_wdata_o, ram_rdata_i;

    dram_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_sel(a_sel), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_stall(a_stall), .a_err(a_err),
        .b_valid(b_valid), .b_we(b_we), .b_sel(b_sel), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_err(b_err),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] ram_mem [0:1023];
    logic [31:0] shadow  [0:1023];

    // Model: who owns the response this cycle (0 none, 1 A, 2 B) and what it returns
    int m_owner, m_wait;
    logic m_we, m_err;
    logic [31:0] m_rdata;
    // Per-cycle decision captured for the post-edge update
    int w_win;
    logic w_we, w_mis, w_bvalid;
    logic [3:0] w_sel;
    logic [AW-1:0] w_addr;
    logic [31:0] w_wdata;
    logic c_ce, c_we;
    logic [3:0] c_sel;
    logic [AW-1:0] c_addr;
    logic [31:0] c_wdata;
    bit ev_a_ack, ev_b_acc, a_busy, b_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mis_f(input logic [3:0] sel, input logic [AW-1:0] addr);
        logic bad;
        bad = ((sel == 4'b0011) && addr[0]) || ((sel == 4'b1111) && (addr[1:0] != 2'b00));
        return ALIGN_EN && bad;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_wait = 0; m_we = 1'b0; m_err = 1'b0; m_rdata = 32'd0;
    endtask

    // Predict this cycle's outputs from the arbitration rules and compare every output
    task automatic compare_all();
        bit a_can, b_can, ce;
        a_can = a_req && (m_owner != 1);
        b_can = b_valid && (m_owner != 2);
        w_win = 0;
        if (!rst) w_win = 0;
        else if (b_can && (!a_can || m_wait == MW)) w_win = 2;
        else if (a_can) w_win = 1;
        w_we    = (w_win == 2) ? b_we : a_we;
        w_sel   = (w_win == 2) ? b_sel : a_sel;
        w_addr  = (w_win == 2) ? b_addr : a_addr;
        w_wdata = (w_win == 2) ? b_wdata : a_wdata;
        w_mis   = (w_win != 0) && mis_f(w_sel, w_addr);
        w_bvalid = b_valid;
        ce = (w_win != 0) && !w_mis;
        chk("ram_ce", 32'(ram_ce_o), 32'(ce));
        chk("ram_we", 32'(ram_we_o), ce ? 32'(w_we) : 32'd0);
        chk("ram_sel", 32'(ram_sel_o), ce ? 32'(w_sel) : 32'd0);
        chk("ram_addr", 32'(ram_addr_o), ce ? 32'(w_addr) : 32'd0);
        chk("ram_wdata", ram_wdata_o, ce ? w_wdata : 32'd0);
        chk("b_ready", 32'(b_ready), 32'(w_win == 2));
        chk("a_stall", 32'(a_stall), 32'(a_req && (m_owner != 1)));
        chk("a_ack", 32'(a_ack), 32'(m_owner == 1));
        chk("a_err", 32'(a_err), 32'((m_owner == 1) && m_err));
        chk("a_rdata", a_rdata, ((m_owner == 1) && !m_we && !m_err) ? m_rdata : 32'd0);
        chk("b_rvalid", 32'(b_rvalid), 32'(m_owner == 2));
        chk("b_err", 32'(b_err), 32'((m_owner == 2) && m_err));
        chk("b_rdata", b_rdata, ((m_owner == 2) && !m_we && !m_err) ? m_rdata : 32'd0);
        c_ce = ram_ce_o; c_we = ram_we_o; c_sel = ram_sel_o; c_addr = ram_addr_o; c_wdata = ram_wdata_o;
    endtask

    // One clock: compare, clock the bench RAM from the DUT pins, advance the model
    task automatic tick();
        logic [31:0] rd;
        int idx;
        #1;
        compare_all();
        @(posedge clk);
        if (c_ce) begin
            rd = ram_mem[c_addr[AW-1:2]];
            if (c_we) ram_mem[c_addr[AW-1:2]] = merge(rd, c_wdata, c_sel);
            ram_rdata_i = rd;
        end
        ev_a_ack = (m_owner == 1);
        ev_b_acc = (w_win == 2);
        if (!rst) begin
            model_reset();
        end else begin
            if (w_win != 0) begin
                idx = int'(w_addr[AW-1:2]);
                m_owner = w_win; m_we = w_we; m_err = w_mis; m_rdata = shadow[idx];
                if (w_we && !w_mis) shadow[idx] = merge(shadow[idx], w_wdata, w_sel);
            end else begin
                m_owner = 0;
            end
            if (w_bvalid && w_win != 2) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
            else m_wait = 0;
        end
        @(negedge clk);
    endtask

    task automatic rand_fields_a();
        a_we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0: a_sel = 4'b0001;
            1: a_sel = 4'b0011;
            default: a_sel = 4'b1111;
        endcase
        a_addr = AW'($urandom_range(0, 63));
        a_wdata = $urandom;
    endtask

    task automatic rand_fields_b();
        b_we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0: b_sel = 4'b0001;
            1: b_sel = 4'b0011;
            default: b_sel = 4'b1111;
        endcase
        b_addr = AW'($urandom_range(0, 63));
        b_wdata = $urandom;
    endtask

    initial begin
        rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_sel = 4'b0000; a_addr = '0; a_wdata = 32'd0;
        b_valid = 1'b0; b_we = 1'b0; b_sel = 4'b0000; b_addr = '0; b_wdata = 32'd0;
        ram_rdata_i = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = 32'hA500_0000 ^ 32'(i * 32'h0001_0101);
            shadow[i]  = ram_mem[i];
        end
        ram_mem[4] = 32'hDEADBEEF;  shadow[4] = 32'hDEADBEEF;
        ram_mem[16] = 32'hCAFEF00D; shadow[16] = 32'hCAFEF00D;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_a_ack", 32'(a_ack), 32'd0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("rst_ram_ce", 32'(ram_ce_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_ram_ce", 32'(ram_ce_o), 32'd0);
            chk("idle_a_stall", 32'(a_stall), 32'd0);
            tick();
        end

        // A load of 0x010
        a_req = 1'b1; a_we = 1'b0; a_sel = 4'b1111; a_addr = 12'h010;
        #1;
        chk("ld_ce", 32'(ram_ce_o), 32'd1);
        chk("ld_addr", 32'(ram_addr_o), 32'h010);
        chk("ld_stall", 32'(a_stall), 32'd1);
        tick();
        #1;
        chk("ld_ack", 32'(a_ack), 32'd1);
        chk("ld_rdata", a_rdata, 32'hDEADBEEF);
        chk("ld_stall_ack", 32'(a_stall), 32'd0);
        tick();
        a_req = 1'b0;

        // A store with a simultaneous B load; B lands in A's ack cycle
        a_req = 1'b1; a_we = 1'b1; a_sel = 4'b1111; a_addr = 12'h020; a_wdata = 32'h12345678;
        b_valid = 1'b1; b_we = 1'b0; b_sel = 4'b1111; b_addr = 12'h040;
        #1;
        chk("st_we", 32'(ram_we_o), 32'd1);
        chk("st_b_ready0", 32'(b_ready), 32'd0);
        tick();
        #1;
        chk("st_ack", 32'(a_ack), 32'd1);
        chk("st_b_ready1", 32'(b_ready), 32'd1);
        chk("st_b_addr", 32'(ram_addr_o), 32'h040);
        tick();
        a_req = 1'b0; b_valid = 1'b0;
        #1;
        chk("st_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("st_b_rdata", b_rdata, 32'hCAFEF00D);
        chk("st_mem", ram_mem[8], 32'h12345678);
        tick();

        // Forced B: B waits through its own response cycle, then beats A
        b_valid = 1'b1; b_we = 1'b0; b_addr = 12'h044;
        tick();
        b_addr = 12'h048;
        #1;
        chk("fb_not_regrant", 32'(b_ready), 32'd0);
        tick();
        a_req = 1'b1; a_we = 1'b0; a_sel = 4'b1111; a_addr = 12'h04C;
        #1;
        chk("fb_b_ready", 32'(b_ready), 32'd1);
        chk("fb_a_stall", 32'(a_stall), 32'd1);
        chk("fb_addr", 32'(ram_addr_o), 32'h048);
        tick();
        b_valid = 1'b0;
        #1;
        chk("fb_a_grant", 32'(ram_addr_o), 32'h04C);
        tick();
        tick();
        a_req = 1'b0;

        // Reset while B's response is due
        b_valid = 1'b1; b_we = 1'b0; b_sel = 4'b1111; b_addr = 12'h040;
        tick();
        b_valid = 1'b0;
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rb_rvalid", 32'(b_rvalid), 32'd0);
        chk("rb_rdata", b_rdata, 32'd0);
        chk("rb_ce", 32'(ram_ce_o), 32'd0);
        tick();
        rst = 1'b1;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        #1;
        chk("rb_after_rvalid", 32'(b_rvalid), 32'd1);
        chk("rb_after_rdata", b_rdata, 32'hCAFEF00D);
        tick();

        // Misaligned word store at 0x003
        a_req = 1'b1; a_we = 1'b1; a_sel = 4'b1111; a_addr = 12'h003; a_wdata = 32'h0BADF00D;
        #1;
        chk("mis_ce", 32'(ram_ce_o), ALIGN_EN ? 32'd0 : 32'd1);
        tick();
        #1;
        chk("mis_ack", 32'(a_ack), 32'd1);
        chk("mis_err", 32'(a_err), 32'(ALIGN_EN));
        tick();
        a_req = 1'b0;
        tick();

        // Random traffic
        a_busy = 1'b0; b_busy = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (ev_a_ack) a_busy = 1'b0;
            if (ev_b_acc) b_busy = 1'b0;
            if (!a_busy && $urandom_range(0, 9) < 6) begin
                rand_fields_a();
                a_busy = 1'b1;
            end
            if (!b_busy) begin
                rand_fields_b();
                if ($urandom_range(0, 9) < 4) b_busy = 1'b1;
            end
            a_req = a_busy;
            b_valid = b_busy;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
